// File: rtl/hermes_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hermes_sequencer
// Brief    : Fetch/issue controller for the Hermes CPU: PC, instruction
//            register, run/step/done control, skip squash, issue counter.
// Revision : 1.0 - initial release
// ============================================================================
module hermes_sequencer #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    OP_WIDTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR    = {ADDR_WIDTH{1'b1}},
  parameter bit                    WRAP        = 1'b1,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   clr_done,
  input  logic                   pc_load,
  input  logic [ADDR_WIDTH-1:0]  pc_load_val,
  input  logic                   skip_req,
  input  logic [OP_WIDTH-1:0]    rom_data,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic [OP_WIDTH-1:0]    instr_out,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] issued_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [OP_WIDTH-1:0]    r_instr;
  logic                   r_valid;
  logic                   r_skip_pend;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_fetch;
  logic w_squash;
  logic w_at_end;
  logic w_load;
  logic w_end_stop;

  assign w_fetch    = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_squash   = (skip_req && r_valid) || r_skip_pend;
  assign w_at_end   = (r_pc == END_ADDR);
  assign w_load     = pc_load && (r_state != S_DONE);
  // An explicit PC load outranks the end-of-program check, so it also cancels the stop.
  assign w_end_stop = w_fetch && w_at_end && !WRAP && !w_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_skip_pend <= 1'b0;
      r_count     <= '0;
    end else begin
      r_valid <= w_fetch && !w_squash;

      if (w_fetch) begin
        r_instr     <= rom_data;
        r_skip_pend <= 1'b0;
        if (!w_squash && (r_count != {COUNT_WIDTH{1'b1}}))
          r_count <= r_count + 1'b1;
      end else if (skip_req && r_valid) begin
        r_skip_pend <= 1'b1;
      end

      if (w_load)
        r_pc <= pc_load_val;
      else if ((r_state == S_DONE) && clr_done)
        r_pc <= '0;
      else if (w_fetch) begin
        if (w_at_end) begin
          if (WRAP)
            r_pc <= '0;
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (run)
            r_state <= S_RUN;
          else if (step)
            r_state <= S_STEP;
        end
        S_RUN:   if (!run) r_state <= S_IDLE;
        S_STEP:  r_state <= S_IDLE;
        S_DONE:  if (clr_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_end_stop)
        r_state <= S_DONE;
    end
  end

  assign rom_addr     = r_pc;
  assign instr_out    = r_instr;
  assign instr_valid  = r_valid;
  assign busy         = (r_state == S_RUN) || (r_state == S_STEP);
  assign done         = (r_state == S_DONE);
  assign issued_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_hermes_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hermes_sequencer
// Brief    : Self-checking bench for hermes_sequencer with a ROM of addr[3:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_hermes_sequencer;

  typedef struct packed {
    logic [3:0] op;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       clr_done = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_val = 8'h00;
  logic       skip_req = 1'b0;

  // a: defaults, b: END=5 no wrap, c: END=5 wrap, d: 3-bit counter
  logic [7:0]  a_addr, b_addr, c_addr, d_addr;
  logic [3:0]  a_instr, b_instr, c_instr, d_instr;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_busy, b_busy, c_busy, d_busy;
  logic        a_done, b_done, c_done, d_done;
  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic [2:0]  d_cnt;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hermes_sequencer u_a (
    .clk(clk), .reset(reset), .run(run), .step(step), .clr_done(clr_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .skip_req(skip_req),
    .rom_data(a_addr[3:0]), .rom_addr(a_addr), .instr_out(a_instr),
    .instr_valid(a_valid), .busy(a_busy), .done(a_done), .issued_count(a_cnt));

  hermes_sequencer #(.END_ADDR(8'h05), .WRAP(1'b0)) u_b (
    .clk(clk), .reset(reset), .run(run), .step(step), .clr_done(clr_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .skip_req(skip_req),
    .rom_data(b_addr[3:0]), .rom_addr(b_addr), .instr_out(b_instr),
    .instr_valid(b_valid), .busy(b_busy), .done(b_done), .issued_count(b_cnt));

  hermes_sequencer #(.END_ADDR(8'h05), .WRAP(1'b1)) u_c (
    .clk(clk), .reset(reset), .run(run), .step(step), .clr_done(clr_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .skip_req(skip_req),
    .rom_data(c_addr[3:0]), .rom_addr(c_addr), .instr_out(c_instr),
    .instr_valid(c_valid), .busy(c_busy), .done(c_done), .issued_count(c_cnt));

  hermes_sequencer #(.COUNT_WIDTH(3)) u_d (
    .clk(clk), .reset(reset), .run(run), .step(step), .clr_done(clr_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .skip_req(skip_req),
    .rom_data(d_addr[3:0]), .rom_addr(d_addr), .instr_out(d_instr),
    .instr_valid(d_valid), .busy(d_busy), .done(d_done), .issued_count(d_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 0; step = 0; clr_done = 0; pc_load = 0; skip_req = 0;
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    run = 1; step = 1; pc_load = 1; pc_load_val = 8'h33; reset = 0;
    tick();
    tick();
    n_tests++; if (a_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h exp 00", a_addr); end
    n_tests++; if (a_instr !== 4'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", a_instr); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", a_valid); end
    n_tests++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL reset_state: busy %b done %b exp 0 0", a_busy, a_done); end
    n_tests++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", a_cnt); end
    do_reset();
  endtask

  task automatic test_run();
    do_reset();
    run = 1;
    for (int k = 1; k <= 5; k++) begin
      e.op = (k >= 2) ? 4'(k - 2) : 4'h0;
      e.v  = (k >= 2);
      q.push_back(e);
      tick();
      e = q.pop_front();
      n_tests++;
      if (a_instr !== e.op || a_valid !== e.v) begin
        n_fail++; $display("FAIL run_instr[%0d]: got %h/%b exp %h/%b", k, a_instr, a_valid, e.op, e.v);
      end
      n_tests++;
      if (a_addr !== 8'(k - 1)) begin n_fail++; $display("FAIL run_pc[%0d]: got %h exp %h", k, a_addr, 8'(k - 1)); end
    end
    n_tests++; if (a_cnt !== 16'd4) begin n_fail++; $display("FAIL run_cnt: got %0d exp 4", a_cnt); end
    tick(); tick(); tick();
    n_tests++; if (a_addr !== 8'h07) begin n_fail++; $display("FAIL run_pc7: got %h exp 07", a_addr); end
    // reset mid-RUN while run stays high
    reset = 0;
    tick();
    n_tests++;
    if (a_addr !== 8'h00 || a_valid !== 1'b0 || a_cnt !== 16'd0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: pc %h valid %b cnt %0d busy %b exp 00 0 0 0", a_addr, a_valid, a_cnt, a_busy);
    end
    reset = 1;
    tick();
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL midrun_rerun: busy %b exp 1", a_busy); end
    run = 0;
    tick();
  endtask

  task automatic test_step();
    do_reset();
    pc_load = 1; pc_load_val = 8'h03;
    tick();
    pc_load = 0; step = 1;
    tick();
    n_tests++; if (a_busy !== 1'b1 || a_valid !== 1'b0) begin n_fail++; $display("FAIL step_busy: busy %b valid %b exp 1 0", a_busy, a_valid); end
    step = 0;
    tick();
    n_tests++;
    if (a_instr !== 4'h3 || a_valid !== 1'b1 || a_addr !== 8'h04 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL step_issue: instr %h valid %b pc %h busy %b exp 3 1 04 0", a_instr, a_valid, a_addr, a_busy);
    end
    tick();
    n_tests++; if (a_valid !== 1'b0 || a_instr !== 4'h3) begin n_fail++; $display("FAIL step_once: instr %h valid %b exp 3 0", a_instr, a_valid); end
    step = 1; tick(); step = 0; tick();
    n_tests++;
    if (a_instr !== 4'h4 || a_valid !== 1'b1 || a_cnt !== 16'd2) begin
      n_fail++; $display("FAIL step_second: instr %h valid %b cnt %0d exp 4 1 2", a_instr, a_valid, a_cnt);
    end
  endtask

  task automatic test_skip_run();
    do_reset();
    run = 1;
    for (int k = 1; k <= 6; k++) begin
      skip_req = (k == 5);
      e.op = (k >= 2) ? 4'(k - 2) : 4'h0;
      e.v  = (k >= 2) && (k != 5);
      q.push_back(e);
      tick();
      e = q.pop_front();
      n_tests++;
      if (a_instr !== e.op || a_valid !== e.v) begin
        n_fail++; $display("FAIL skip_run[%0d]: got %h/%b exp %h/%b", k, a_instr, a_valid, e.op, e.v);
      end
      if (k == 5) begin
        n_tests++; if (a_cnt !== 16'd3) begin n_fail++; $display("FAIL skip_cnt: got %0d exp 3", a_cnt); end
      end
    end
    skip_req = 0; run = 0;
    tick();
  endtask

  task automatic test_skip_pend();
    do_reset();
    pc_load = 1; pc_load_val = 8'h05;
    tick();
    pc_load = 0; step = 1; tick(); step = 0; tick();
    n_tests++; if (a_instr !== 4'h5 || a_valid !== 1'b1) begin n_fail++; $display("FAIL pend_snz: got %h/%b exp 5/1", a_instr, a_valid); end
    skip_req = 1; tick(); skip_req = 0;
    tick(); tick();
    step = 1; tick(); step = 0; tick();
    n_tests++;
    if (a_instr !== 4'h6 || a_valid !== 1'b0 || a_addr !== 8'h07 || a_cnt !== 16'd1) begin
      n_fail++; $display("FAIL pend_squash: instr %h valid %b pc %h cnt %0d exp 6 0 07 1", a_instr, a_valid, a_addr, a_cnt);
    end
    step = 1; tick(); step = 0; tick();
    n_tests++; if (a_instr !== 4'h7 || a_valid !== 1'b1) begin n_fail++; $display("FAIL pend_next: got %h/%b exp 7/1", a_instr, a_valid); end
  endtask

  task automatic test_pc_load_fetch();
    do_reset();
    run = 1; tick(); tick();
    pc_load = 1; pc_load_val = 8'h20;
    tick();
    n_tests++;
    if (a_instr !== 4'h1 || a_valid !== 1'b1 || a_addr !== 8'h20) begin
      n_fail++; $display("FAIL load_fetch: instr %h valid %b pc %h exp 1 1 20", a_instr, a_valid, a_addr);
    end
    pc_load = 0; tick();
    n_tests++; if (a_instr !== 4'h0 || a_addr !== 8'h21) begin n_fail++; $display("FAIL load_next: instr %h pc %h exp 0 21", a_instr, a_addr); end
    run = 0; tick();
  endtask

  task automatic test_end();
    do_reset();
    run = 1;
    for (int k = 1; k <= 7; k++) tick();
    n_tests++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_addr !== 8'h05 || b_instr !== 4'h5 || b_valid !== 1'b1 || b_cnt !== 16'd6) begin
      n_fail++; $display("FAIL end_done: done %b busy %b pc %h instr %h valid %b cnt %0d exp 1 0 05 5 1 6",
                         b_done, b_busy, b_addr, b_instr, b_valid, b_cnt);
    end
    pc_load = 1; pc_load_val = 8'h02; step = 1;
    tick();
    pc_load = 0; step = 0;
    n_tests++;
    if (b_done !== 1'b1 || b_addr !== 8'h05 || b_valid !== 1'b0) begin
      n_fail++; $display("FAIL end_hold: done %b pc %h valid %b exp 1 05 0", b_done, b_addr, b_valid);
    end
    run = 0; clr_done = 1;
    tick();
    clr_done = 0;
    n_tests++;
    if (b_done !== 1'b0 || b_busy !== 1'b0 || b_addr !== 8'h00) begin
      n_fail++; $display("FAIL end_clr: done %b busy %b pc %h exp 0 0 00", b_done, b_busy, b_addr);
    end
    // wrapping variant from PC=4
    do_reset();
    pc_load = 1; pc_load_val = 8'h04; tick(); pc_load = 0;
    run = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (c_addr !== ((k < 2) ? 8'(4 + k) : 8'(k - 2)) || c_done !== 1'b0) begin
        n_fail++; $display("FAIL wrap_pc[%0d]: got %h done %b exp %h 0", k, c_addr, c_done,
                           (k < 2) ? 8'(4 + k) : 8'(k - 2));
      end
    end
    run = 0; tick();
  endtask

  task automatic test_saturate();
    do_reset();
    run = 1;
    for (int k = 0; k < 12; k++) tick();
    n_tests++; if (d_cnt !== 3'd7) begin n_fail++; $display("FAIL cnt_sat: got %0d exp 7", d_cnt); end
    run = 0; tick();
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_skip_run();
    test_skip_pend();
    test_pc_load_fetch();
    test_end();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
